mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 78 +++++++
 tb/tb_mem_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline MEM stage: branch resolution, doubleword data memory and the MEM/WB register.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int MEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_MEM_Branch,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_RegWrite,
  input  logic        EX_MEM_MemtoReg,
  input  logic        EX_MEM_Zero,
  input  logic [4:0]  EX_MEM_rd,
  input  logic [63:0] EX_MEM_ALU_Out,
  input  logic [63:0] EX_MEM_MUX_ForwardB,
  input  logic [63:0] EX_MEM_PC_Adder,
  output logic        PCSrc,
  output logic [63:0] Branch_Target,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_MemtoReg,
  output logic [4:0]  MEM_WB_rd,
  output logic [63:0] MEM_WB_ReadData,
  output logic [63:0] MEM_WB_ALU_Out,
  output logic        Mem_Misaligned
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  // Memory must clear on reset and read asynchronously, so it is kept in registers.
  logic [63:0]      mem_reg [MEM_DEPTH];
  logic [IDX_W-1:0] word_idx;
  logic             misaligned;
  logic             write_en;
  logic [63:0]      read_next;

  assign PCSrc         = EX_MEM_Branch & EX_MEM_Zero;
  assign Branch_Target = EX_MEM_PC_Adder;

  // Upper address bits are dropped, so addresses wrap around the memory size.
  assign word_idx = EX_MEM_ALU_Out[3 +: IDX_W];

`ifdef MEM_ALIGN_CHECK_EN
  logic access;
  assign access     = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign misaligned = access & (|EX_MEM_ALU_Out[2:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign write_en  = EX_MEM_MemWrite & ~misaligned;
  assign read_next = (EX_MEM_MemRead & ~misaligned) ? mem_reg[word_idx] : 64'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_reg[i] <= 64'd0;
      end
      MEM_WB_RegWrite <= 1'b0;
      MEM_WB_MemtoReg <= 1'b0;
      MEM_WB_rd       <= 5'd0;
      MEM_WB_ReadData <= 64'd0;
      MEM_WB_ALU_Out  <= 64'd0;
      Mem_Misaligned  <= 1'b0;
    end else begin
      if (write_en) begin
        mem_reg[word_idx] <= EX_MEM_MUX_ForwardB;
      end
      MEM_WB_RegWrite <= EX_MEM_RegWrite & ~misaligned;
      MEM_WB_MemtoReg <= EX_MEM_MemtoReg;
      MEM_WB_rd       <= EX_MEM_rd;
      MEM_WB_ReadData <= read_next;
      MEM_WB_ALU_Out  <= EX_MEM_ALU_Out;
      Mem_Misaligned  <= misaligned;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: each driven cycle pushes its expected MEM/WB result,
// which is popped and compared one edge later; branch outputs are checked combinationally.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_MEM_Branch, EX_MEM_MemRead, EX_MEM_MemWrite;
  logic        EX_MEM_RegWrite, EX_MEM_MemtoReg, EX_MEM_Zero;
  logic [4:0]  EX_MEM_rd;
  logic [63:0] EX_MEM_ALU_Out, EX_MEM_MUX_ForwardB, EX_MEM_PC_Adder;
  logic        PCSrc;
  logic [63:0] Branch_Target;
  logic        MEM_WB_RegWrite, MEM_WB_MemtoReg;
  logic [4:0]  MEM_WB_rd;
  logic [63:0] MEM_WB_ReadData, MEM_WB_ALU_Out;
  logic        Mem_Misaligned;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic [4:0]  rd;
    logic [63:0] rdata;
    logic [63:0] alu;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model_mem [64];

  mem_stage #(.MEM_DEPTH(64)) dut (
    .clk                 (clk),
    .reset               (reset),
    .EX_MEM_Branch       (EX_MEM_Branch),
    .EX_MEM_MemRead      (EX_MEM_MemRead),
    .EX_MEM_MemWrite     (EX_MEM_MemWrite),
    .EX_MEM_RegWrite     (EX_MEM_RegWrite),
    .EX_MEM_MemtoReg     (EX_MEM_MemtoReg),
    .EX_MEM_Zero         (EX_MEM_Zero),
    .EX_MEM_rd           (EX_MEM_rd),
    .EX_MEM_ALU_Out      (EX_MEM_ALU_Out),
    .EX_MEM_MUX_ForwardB (EX_MEM_MUX_ForwardB),
    .EX_MEM_PC_Adder     (EX_MEM_PC_Adder),
    .PCSrc               (PCSrc),
    .Branch_Target       (Branch_Target),
    .MEM_WB_RegWrite     (MEM_WB_RegWrite),
    .MEM_WB_MemtoReg     (MEM_WB_MemtoReg),
    .MEM_WB_rd           (MEM_WB_rd),
    .MEM_WB_ReadData     (MEM_WB_ReadData),
    .MEM_WB_ALU_Out      (MEM_WB_ALU_Out),
    .Mem_Misaligned      (Mem_Misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Drive one EX/MEM cycle, predict the MEM/WB result, then compare after the edge.
  task automatic step(input logic rst, input logic br, input logic zero,
                      input logic mr, input logic mw, input logic rw, input logic mtr,
                      input logic [4:0] rd, input logic [63:0] addr,
                      input logic [63:0] data, input logic [63:0] pc);
    exp_t e;
    exp_t got;
    logic mis;
    logic [5:0] idx;
    reset               = rst;
    EX_MEM_Branch       = br;
    EX_MEM_Zero         = zero;
    EX_MEM_MemRead      = mr;
    EX_MEM_MemWrite     = mw;
    EX_MEM_RegWrite     = rw;
    EX_MEM_MemtoReg     = mtr;
    EX_MEM_rd           = rd;
    EX_MEM_ALU_Out      = addr;
    EX_MEM_MUX_ForwardB = data;
    EX_MEM_PC_Adder     = pc;

    idx = addr[8:3];
`ifdef MEM_ALIGN_CHECK_EN
    mis = (mr | mw) && (addr[2:0] != 3'd0);
`else
    mis = 1'b0;
`endif
    if (rst) begin
      e = '0;
      for (int i = 0; i < 64; i++) model_mem[i] = 64'd0;
    end else begin
      e.rw    = rw & ~mis;
      e.mtr   = mtr;
      e.rd    = rd;
      e.rdata = (mr && !mis) ? model_mem[idx] : 64'd0;
      e.alu   = addr;
      e.mis   = mis;
      if (mw && !mis) model_mem[idx] = data;
    end
    exp_q.push_back(e);

    #1;
    check("pcsrc", {63'd0, PCSrc}, {63'd0, br & zero});
    check("branch_target", Branch_Target, pc);

    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    txn++;
    $display("txn %0d rst=%0b rd=%0b wr=%0b addr=%h data=%h -> rdata=%h rd=%0d rw=%0b mis=%0b",
             txn, rst, mr, mw, addr, data, MEM_WB_ReadData, MEM_WB_rd, MEM_WB_RegWrite, Mem_Misaligned);
    check("readdata", MEM_WB_ReadData, got.rdata);
    check("regwrite", {63'd0, MEM_WB_RegWrite}, {63'd0, got.rw});
    check("memtoreg", {63'd0, MEM_WB_MemtoReg}, {63'd0, got.mtr});
    check("rd", {59'd0, MEM_WB_rd}, {59'd0, got.rd});
    check("alu_out", MEM_WB_ALU_Out, got.alu);
    check("misaligned", {63'd0, Mem_Misaligned}, {63'd0, got.mis});
  endtask

  initial begin
    // Dirty a word, then reset for two cycles with a store pending that must be discarded.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 64'h18, 64'hAAAA, 64'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 64'h28, 64'hBBBB, 64'h10);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 64'h28, 64'hBBBB, 64'h20);
    // Loads after reset see cleared memory.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'h18, 64'h0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 64'h28, 64'h0, 64'h0);

    // Store then back-to-back load.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h20, 64'hDEADBEEF_CAFEF00D, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 64'h20, 64'h0, 64'h0);

    // Wrap-around: 0x200 aliases word 0.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h200, 64'h1234, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 64'h0, 64'h0, 64'h0);

    // Branch taken and not taken.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h40);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h40);

    // Simultaneous read/write returns old data; following load sees new data.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 64'h8, 64'h11, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 64'h8, 64'h22, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 64'h8, 64'h0, 64'h0);

    // Unaligned store then aligned load of the same word.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 64'h21, 64'h55, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 64'h20, 64'h0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 64'h23, 64'h0, 64'h0);

    // Random traffic over a small address window to force reuse of words.
    for (int n = 0; n < 60; n++) begin
      logic [63:0] a;
      logic [63:0] d;
      logic [4:0]  r;
      a = {$urandom, $urandom} & 64'h0000_0000_0000_03FF;
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'd0;
      d = {$urandom, $urandom};
      r = 5'($urandom);
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), r, a, d, {$urandom, $urandom});
    end

    // Reset again clears everything written by the random phase.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0);
    for (int w = 0; w < 64; w += 9) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'(w), 64'(w * 8), 64'h0, 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
